// File: rtl/usb_uart_tx_fifo.sv
// Device-to-host byte FIFO feeding a USB UART: first-word-fall-through output,
// registered flags (in_ready, uart_in_valid, almost_full) derived from the next occupancy.
module usb_uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned AFULL_LEVEL = 48
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            uart_in_data,
  output logic                  uart_in_valid,
  input  logic                  uart_in_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   LevelFull  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   LevelAfull = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LevelOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne     = DEPTH_LOG2'(1);

  logic [7:0] mem [Depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  valid_q, valid_d;
  logic                  afull_q, afull_d;

  logic push, pop;

  // Handshakes qualify on registered flags only, so full blocks pushes even when a pop
  // happens on the same edge.
  assign push = in_valid && in_ready_q;
  assign pop  = valid_q && uart_in_ready;

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d != LevelFull);
    valid_d    = (level_d != '0);
    afull_d    = (level_d >= LevelAfull);
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      afull_q    <= afull_d;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // Head read is combinational so a byte written into an empty FIFO is visible right after
  // its push edge.
  assign uart_in_data  = mem[rd_ptr_q];
  assign uart_in_valid = valid_q;
  assign in_ready      = in_ready_q;
  assign level         = level_q;
  assign almost_full   = afull_q;

endmodule

// File: tb/tb_usb_uart_tx_fifo.sv
// Randomised self-checking bench for usb_uart_tx_fifo; a byte queue is the reference model.
module tb_usb_uart_tx_fifo;

  localparam int Depth = 64;
  localparam int Afull = 48;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic [6:0] level;
  logic       almost_full;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  usb_uart_tx_fifo #(
    .DEPTH_LOG2  (6),
    .AFULL_LEVEL (48)
  ) dut (
    .clk_48mhz     (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready),
    .level         (level),
    .almost_full   (almost_full)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, update the model, settle 1 time unit past the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit do_push, do_pop;
    in_valid = v;
    in_data = d;
    uart_in_ready = r;
    do_push = v && (q.size() < Depth);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; uart_in_ready = 1'b0;
    #3;
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", uart_in_valid); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_hold_level: got %0d want 0", level); end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_single;
    cycle(1'b1, 8'h41, 1'b0);
    checks++; if (uart_in_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", uart_in_valid); end
    checks++; if (uart_in_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", uart_in_data); end
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL single_drain_level: got %0d want 0", level); end
    checks++; if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", uart_in_valid); end
  endtask

  task automatic test_fill_full;
    for (int i = 0; i < Depth; i++) cycle(1'b1, 8'(i), 1'b0);
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL full_level: got %0d want 64", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_afull: got %b want 1", almost_full); end
    cycle(1'b1, 8'hFF, 1'b0);
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL full_ignore_level: got %0d want 64", level); end
    checks++; if (uart_in_data !== 8'h00) begin errors++; $display("FAIL full_ignore_head: got %h want 00", uart_in_data); end
    for (int i = 0; i < Depth; i++) begin
      checks++; if (uart_in_valid !== 1'b1 || uart_in_data !== 8'(i)) begin
        errors++; $display("FAIL full_drain_data[%0d]: got %b/%h want 1/%h", i, uart_in_valid, uart_in_data, 8'(i));
      end
      // First pop carries a push attempt: full on that edge, so it must be dropped.
      cycle(i == 0, 8'hEE, 1'b1);
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
        checks++; if (level !== 7'd63) begin errors++; $display("FAIL full_pop_level: got %0d want 63", level); end
      end
    end
    checks++; if (level !== 7'd0 || uart_in_valid !== 1'b0) begin
      errors++; $display("FAIL full_drain_end: got level %0d valid %b want 0 0", level, uart_in_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) begin
        checks++; if (uart_in_data !== 8'(i - 1)) begin
          errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, uart_in_data, 8'(i - 1));
        end
      end
      cycle(1'b1, 8'(i), 1'b1);
      checks++; if (level !== 7'd1 || uart_in_valid !== 1'b1) begin
        errors++; $display("FAIL stream_level[%0d]: got %0d/%b want 1/1", i, level, uart_in_valid);
      end
    end
    checks++; if (uart_in_data !== 8'd199) begin errors++; $display("FAIL stream_last: got %h want c7", uart_in_data); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL stream_end_level: got %0d want 0", level); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
      checks++; if (int'(level) != q.size()) begin
        errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", n, level, q.size());
      end
      checks++; if (almost_full !== (q.size() >= Afull)) begin
        errors++; $display("FAIL rand_afull[%0d]: got %b want %b", n, almost_full, q.size() >= Afull);
      end
      checks++; if (in_ready !== (q.size() < Depth) || uart_in_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL rand_flags[%0d]: got rdy %b vld %b size %0d", n, in_ready, uart_in_valid, q.size());
      end
      if (q.size() > 0) begin
        checks++; if (uart_in_data !== q[0]) begin
          errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, uart_in_data, q[0]);
        end
      end
    end
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL rand_drain: got %0d want 0", level); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    checks++; if (level !== 7'd10) begin errors++; $display("FAIL areset_pre_level: got %0d want 10", level); end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (uart_in_valid !== 1'b0 || level !== 7'd0) begin
      errors++; $display("FAIL areset_async: got valid %b level %0d want 0 0", uart_in_valid, level);
    end
    checks++; if (in_ready !== 1'b1 || almost_full !== 1'b0) begin
      errors++; $display("FAIL areset_flags: got rdy %b afull %b want 1 0", in_ready, almost_full);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 8'hA5, 1'b0);
    checks++; if (uart_in_valid !== 1'b1 || uart_in_data !== 8'hA5) begin
      errors++; $display("FAIL areset_first: got %b/%h want 1/a5", uart_in_valid, uart_in_data);
    end
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL areset_level: got %0d want 1", level); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_almost_full;
    for (int i = 0; i < 47; i++) cycle(1'b1, 8'(i), 1'b0);
    checks++; if (almost_full !== 1'b0 || level !== 7'd47) begin
      errors++; $display("FAIL afull_47: got afull %b level %0d want 0 47", almost_full, level);
    end
    cycle(1'b1, 8'd47, 1'b0);
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL afull_48: got %b want 1", almost_full); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (almost_full !== 1'b0 || level !== 7'd47) begin
      errors++; $display("FAIL afull_pop: got afull %b level %0d want 0 47", almost_full, level);
    end
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_full();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_almost_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
